freq_bcd_converter: RTL

Sequential binary-to-BCD converter that sits directly downstream of the frequency counter. It takes the 32-bit pulses-per-second count, converts it to packed decimal digits with a one-bit-per-cycle shift-add-3 (double-dabble) engine, and presents the digits, a significant-digit count and an overflow flag. Its outputs feed the 7-segment/LED display scanner.

---
 rtl/freq_bcd_converter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/freq_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter with significant-digit count and saturation.
// Optional leading-zero blanking when FREQ_BCD_LZB_EN is defined.
module freq_bcd_converter #(
    parameter int IN_W   = 32,
    parameter int DIGITS = 10
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       bin_in,
    input  logic                  bin_valid,
    output logic                  bin_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic [3:0]            sig_digits,
    output logic                  ovf,
    output logic [1:0]            dbg_state_o
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + IN_W;
    localparam int CW = $clog2(IN_W + 1);

    // Handshake: an input is taken on any edge where bin_valid && bin_ready;
    // bin_valid while busy is dropped, and bcd_valid is a single-cycle pulse.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic [3:0]       sig_q, sig_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic [SW-1:0]    adj;
    logic [BW-1:0]    raw;
    logic [BW-1:0]    res;
    logic [3:0]       sig_calc;
    logic [3:0]       sig_fin;

    // Add-3 correction on every BCD nibble before the shift.
    always_comb begin
        adj = sh_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sh_q[IN_W+4*i +: 4] >= 4'd5) begin
                adj[IN_W+4*i +: 4] = sh_q[IN_W+4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        raw      = sh_q[SW-1:IN_W];
        sig_calc = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (raw[4*i +: 4] != 4'd0) begin
                sig_calc = 4'(i + 1);
            end
        end
        sig_fin = sticky_q ? 4'(DIGITS) : sig_calc;
        res     = raw;
        if (sticky_q) begin
            for (int i = 0; i < DIGITS; i++) begin
                res[4*i +: 4] = 4'd9;
            end
        end
`ifdef FREQ_BCD_LZB_EN
        for (int i = 1; i < DIGITS; i++) begin
            if (i >= int'(sig_fin)) begin
                res[4*i +: 4] = 4'hF;
            end
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        sig_d    = sig_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bin_valid) begin
                    sh_d     = {{BW{1'b0}}, bin_in};
                    cnt_d    = CW'(IN_W);
                    sticky_d = 1'b0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sh_d     = {adj[SW-2:0], 1'b0};
                sticky_d = sticky_q | adj[SW-1];
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d   = res;
                sig_d   = sig_fin;
                ovf_d   = sticky_q;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sh_q     <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            sig_q    <= 4'd1;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            sig_q    <= sig_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign bin_ready   = (state_q == S_IDLE);
    assign bcd_out     = bcd_q;
    assign bcd_valid   = valid_q;
    assign sig_digits  = sig_q;
    assign ovf         = ovf_q;
    assign dbg_state_o = state_q;

endmodule
